// File: rtl/bandscope_capture.sv
// Bandscope capture: periodic trigger, ping-pong bank fill, reader handoff.
// Optional macro BS_DECIM_EN adds a decim input (write every decim+1 strobes).
module bandscope_capture #(
  parameter int ADDR_W   = 14,
  parameter int PERIOD_W = 8,
  parameter int TICK_DIV = 400,
  parameter int FCNT_W   = 8
`ifdef BS_DECIM_EN
  ,
  parameter int DECIM_W  = 4
`endif
) (
  input  logic                clock,
  input  logic                rst_n,
  input  logic                bs_on,
  input  logic [PERIOD_W-1:0] bs_period,
  input  logic                single,
  input  logic                sample_valid,
  input  logic                rd_done,
`ifdef BS_DECIM_EN
  input  logic [DECIM_W-1:0]  decim,
`endif
  output logic                mem_we,
  output logic [ADDR_W:0]     mem_addr,
  output logic                bs_ready,
  output logic                rd_bank,
  output logic                busy,
  output logic                overrun,
  output logic [FCNT_W-1:0]   frame_cnt
);

  localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_FILL,
    S_DONE,
    S_HALT
  } state_t;

  state_t              state_q, state_d;
  logic [PS_W-1:0]     ps_q, ps_d;
  logic [PERIOD_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                last_q, last_d;
  logic                wbank_q, wbank_d;
  logic                we_q, we_d;
  logic [ADDR_W:0]     addr_q, addr_d;
  logic                ready_q, ready_d;
  logic                rd_bank_q, rd_bank_d;
  logic                ovr_q, ovr_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;

  logic                tick;
  logic                trig;
  logic                take;
  logic [PERIOD_W-1:0] pc_inc;

`ifdef BS_DECIM_EN
  logic [DECIM_W-1:0]  ph_q, ph_d;
  assign take = (ph_q == '0);
`else
  assign take = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    ps_d      = ps_q;
    pc_d      = pc_q;
    idx_d     = idx_q;
    last_d    = last_q;
    wbank_d   = wbank_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    ready_d   = ready_q;
    rd_bank_d = rd_bank_q;
    ovr_d     = ovr_q;
    fcnt_d    = fcnt_q;
`ifdef BS_DECIM_EN
    ph_d      = ph_q;
`endif

    tick   = bs_on && (ps_q == PS_LAST);
    pc_inc = pc_q + 1'b1;
    // Period 0 re-arms as soon as the previous frame has finished
    if (bs_period == '0) begin
      trig = (state_q == S_WAIT);
    end else begin
      trig = tick && (pc_inc == bs_period);
    end

    if (!bs_on) begin
      state_d = S_IDLE;
      ps_d    = '0;
      pc_d    = '0;
      idx_d   = '0;
      last_d  = 1'b0;
      ready_d = 1'b0;
      ovr_d   = 1'b0;
`ifdef BS_DECIM_EN
      ph_d    = '0;
`endif
    end else begin
      ps_d = tick ? '0 : ps_q + 1'b1;
      if (tick) begin
        pc_d = (trig || bs_period == '0) ? '0 : pc_inc;
      end
      if (rd_done) begin
        ready_d = 1'b0;
      end

      unique case (state_q)
        S_IDLE: state_d = S_WAIT;
        S_WAIT: begin
          if (trig) begin
            state_d = S_FILL;
            idx_d   = '0;
            last_d  = 1'b0;
`ifdef BS_DECIM_EN
            ph_d    = '0;
`endif
          end
        end
        S_FILL: begin
          if (trig) begin
            ovr_d = 1'b1;
          end
          if (last_q) begin
            state_d = S_DONE;
          end else if (sample_valid) begin
`ifdef BS_DECIM_EN
            ph_d = (ph_q == decim) ? '0 : ph_q + 1'b1;
`endif
            if (take) begin
              we_d   = 1'b1;
              addr_d = {wbank_q, idx_q};
              idx_d  = idx_q + 1'b1;
              last_d = &idx_q;
            end
          end
        end
        S_DONE: begin
          fcnt_d = fcnt_q + 1'b1;
          // A same-cycle rd_done frees the reader bank for this handoff
          if (!ready_q || rd_done) begin
            rd_bank_d = wbank_q;
            ready_d   = 1'b1;
            wbank_d   = ~wbank_q;
          end
          state_d = single ? S_HALT : S_WAIT;
        end
        S_HALT: state_d = S_HALT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ps_q      <= '0;
      pc_q      <= '0;
      idx_q     <= '0;
      last_q    <= 1'b0;
      wbank_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      ready_q   <= 1'b0;
      rd_bank_q <= 1'b0;
      ovr_q     <= 1'b0;
      fcnt_q    <= '0;
`ifdef BS_DECIM_EN
      ph_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ps_q      <= ps_d;
      pc_q      <= pc_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      wbank_q   <= wbank_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      ready_q   <= ready_d;
      rd_bank_q <= rd_bank_d;
      ovr_q     <= ovr_d;
      fcnt_q    <= fcnt_d;
`ifdef BS_DECIM_EN
      ph_q      <= ph_d;
`endif
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign bs_ready  = ready_q;
  assign rd_bank   = rd_bank_q;
  assign busy      = (state_q == S_FILL);
  assign overrun   = ovr_q;
  assign frame_cnt = fcnt_q;

endmodule

// File: tb/tb_bandscope_capture.sv
// Bench for bandscope_capture: vector table, corner sequences, random model.
// Small geometry: 16-sample banks, 4-clock period unit.
module tb_bandscope_capture;

  localparam int AW = 4;
  localparam int PW = 8;
  localparam int TD = 4;
  localparam int FW = 8;

  typedef struct {
    int period;
    int gap;
    int frames;
    bit ack;
    bit single;
    int exp_fcnt;
    bit exp_ready;
    bit exp_rdb;
    bit exp_ovr;
    int exp_wr;
    int exp_b1;
  } vec_t;

  logic          clock = 1'b0;
  logic          rst_n = 1'b0;
  logic          bs_on = 1'b0;
  logic [PW-1:0] bs_period = '0;
  logic          single = 1'b0;
  logic          sample_valid = 1'b0;
  logic          rd_done = 1'b0;
`ifdef BS_DECIM_EN
  logic [3:0]    decim = '0;
`endif
  logic          mem_we;
  logic [AW:0]   mem_addr;
  logic          bs_ready;
  logic          rd_bank;
  logic          busy;
  logic          overrun;
  logic [FW-1:0] frame_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int b1_cnt = 0;
  int first_wr = 0;
  int last_wr = 0;
  logic [AW:0] last_addr = '0;

  bit            model_on = 1'b0;
  bit            m_wb, m_ready, m_rdb;
  logic [FW-1:0] m_fcnt;
  logic [AW-1:0] m_idx;
  int            pend;
  bit            rd_applied, sv_applied;

  bandscope_capture #(
    .ADDR_W(AW),
    .PERIOD_W(PW),
    .TICK_DIV(TD),
    .FCNT_W(FW)
`ifdef BS_DECIM_EN
    ,
    .DECIM_W(4)
`endif
  ) dut (
    .clock(clock),
    .rst_n(rst_n),
    .bs_on(bs_on),
    .bs_period(bs_period),
    .single(single),
    .sample_valid(sample_valid),
    .rd_done(rd_done),
`ifdef BS_DECIM_EN
    .decim(decim),
`endif
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .bs_ready(bs_ready),
    .rd_bank(rd_bank),
    .busy(busy),
    .overrun(overrun),
    .frame_cnt(frame_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: frame handoff rules, applied at the DONE edge,
  // which falls two cycles after the last write of a frame is seen.
  task automatic model_step();
    if (pend == 1) begin
      m_fcnt++;
      if (!m_ready || rd_applied) begin
        m_rdb   = m_wb;
        m_ready = 1'b1;
        m_wb    = !m_wb;
      end
    end else if (rd_applied) begin
      m_ready = 1'b0;
    end
    if (pend > 0) pend--;
    chk("rnd_ready", bs_ready, m_ready);
    chk("rnd_rdbank", rd_bank, m_rdb);
    chk("rnd_fcnt", frame_cnt, m_fcnt);
    if (mem_we) begin
      chk("rnd_addr", mem_addr, {m_wb, m_idx});
      chk("rnd_strobe", sv_applied, 1);
      if (m_idx == '1) pend = 2;
      m_idx++;
    end
  endtask

  task automatic step();
    @(posedge clock);
    rd_applied = rd_done;
    sv_applied = sample_valid;
    @(negedge clock);
    cyc++;
    if (mem_we) begin
      wr_cnt++;
      last_addr = mem_addr;
      last_wr = cyc;
      if (wr_cnt == 1) first_wr = cyc;
      if (mem_addr[AW]) b1_cnt++;
    end
    if (model_on) model_step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bs_on = 1'b0;
    bs_period = '0;
    single = 1'b0;
    sample_valid = 1'b0;
    rd_done = 1'b0;
`ifdef BS_DECIM_EN
    decim = '0;
`endif
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    wr_cnt = 0;
    b1_cnt = 0;
    first_wr = 0;
    last_wr = 0;
    last_addr = '0;
    m_wb = 0;
    m_ready = 0;
    m_rdb = 0;
    m_fcnt = '0;
    m_idx = '0;
    pend = 0;
  endtask

  // Strobe every gap cycles until target writes are seen; optional
  // reader ack four cycles after each non-final frame completes.
  task automatic run_until(input int target, input int gap, input bit ack);
    int budget;
    int ack_at;
    int prev;
    budget = 0;
    ack_at = -1;
    while (wr_cnt < target && budget < 4000) begin
      sample_valid = (cyc % gap == 0);
      rd_done = ack && (cyc == ack_at);
      prev = wr_cnt;
      step();
      budget++;
      if (wr_cnt != prev && wr_cnt % 16 == 0 && wr_cnt < target)
        ack_at = cyc + 4;
    end
    rd_done = 1'b0;
    chk("wr_reach", wr_cnt, target);
  endtask

  initial begin
    vec_t tbl[6];
    vec_t v;

    tbl[0] = '{2, 1, 1, 0, 0, 1, 1, 0, 1, 16, 0};
    tbl[1] = '{8, 1, 3, 0, 0, 3, 1, 0, 0, 48, 32};
    tbl[2] = '{1, 4, 1, 0, 0, 1, 1, 0, 1, 16, 0};
    tbl[3] = '{12, 2, 2, 1, 0, 2, 1, 1, 0, 32, 16};
    tbl[4] = '{0, 1, 4, 1, 0, 4, 1, 1, 0, 64, 32};
    tbl[5] = '{2, 1, 1, 0, 1, 1, 1, 0, 1, 16, 0};

    do_reset();
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_ready", bs_ready, 0);
    chk("rst_rdbank", rd_bank, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_fcnt", frame_cnt, 0);

    // First trigger lands exactly 8 clocks after enable
    bs_period = 2;
    sample_valid = 1'b1;
    bs_on = 1'b1;
    repeat (7) step();
    chk("trig_early", busy, 0);
    step();
    chk("trig_at8", busy, 1);
    step();
    chk("first_we", mem_we, 1);
    chk("first_addr", mem_addr, 0);
    run_until(16, 1, 0);
    chk("f1_last_addr", last_addr, 5'h0F);
    repeat (3) step();
    chk("f1_ready", bs_ready, 1);
    chk("f1_rdbank", rd_bank, 0);
    chk("f1_fcnt", frame_cnt, 1);
    run_until(32, 1, 0);
    chk("f2_last_addr", last_addr, 5'h1F);
    chk("f2_bank1_wr", b1_cnt, 16);

    foreach (tbl[k]) begin
      v = tbl[k];
      do_reset();
      bs_period = PW'(v.period);
      single = v.single;
      bs_on = 1'b1;
      run_until(v.frames * 16, v.gap, v.ack);
      if (!v.single) sample_valid = 1'b0;
      repeat (v.single ? 100 : 6) step();
      chk($sformatf("v%0d_fcnt", k), frame_cnt, v.exp_fcnt);
      chk($sformatf("v%0d_ready", k), bs_ready, v.exp_ready);
      chk($sformatf("v%0d_rdbank", k), rd_bank, v.exp_rdb);
      chk($sformatf("v%0d_ovr", k), overrun, v.exp_ovr);
      chk($sformatf("v%0d_wr", k), wr_cnt, v.exp_wr);
      chk($sformatf("v%0d_b1", k), b1_cnt, v.exp_b1);
      if (v.single) chk($sformatf("v%0d_busy", k), busy, 0);
    end

    // Single mode re-armed by toggling bs_on
    bs_on = 1'b0;
    step();
    bs_on = 1'b1;
    run_until(32, 1, 0);
    chk("single_rearm_addr", last_addr, 5'h1F);
    chk("single_rearm_b1", b1_cnt, 16);

    // rd_done coincident with DONE: new bank handed off at once
    do_reset();
    bs_period = 8;
    bs_on = 1'b1;
    run_until(16, 1, 0);
    run_until(32, 1, 0);
    sample_valid = 1'b0;
    step();
    rd_done = 1'b1;
    step();
    rd_done = 1'b0;
    chk("coin_ready", bs_ready, 1);
    chk("coin_rdbank", rd_bank, 1);
    chk("coin_fcnt", frame_cnt, 2);

    // Abort mid-frame, restart, then async reset mid-fill
    do_reset();
    bs_period = 8;
    bs_on = 1'b1;
    run_until(16, 1, 0);
    sample_valid = 1'b0;
    repeat (4) step();
    chk("abort_pre_ready", bs_ready, 1);
    run_until(24, 1, 0);
    chk("abort_idx7", last_addr, 5'h17);
    bs_on = 1'b0;
    step();
    chk("abort_we", mem_we, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", bs_ready, 0);
    chk("abort_ovr", overrun, 0);
    chk("abort_fcnt", frame_cnt, 1);
    bs_on = 1'b1;
    run_until(25, 1, 0);
    chk("restart_addr", last_addr, 5'h10);
    repeat (2) step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_we", mem_we, 0);
    chk("arst_busy", busy, 0);
    chk("arst_fcnt", frame_cnt, 0);
    chk("arst_addr", mem_addr, 0);
    chk("arst_ready", bs_ready, 0);
    do_reset();

`ifdef BS_DECIM_EN
    // decim=2: strobes 0,3,...,45 are written
    do_reset();
    decim = 4'd2;
    bs_period = 12;
    bs_on = 1'b1;
    run_until(16, 1, 0);
    chk("decim_span", last_wr - first_wr, 45);
    chk("decim_last", last_addr, 5'h0F);
    sample_valid = 1'b0;
    decim = '0;
`endif

    for (int s = 0; s < 3; s++) begin
      do_reset();
      bs_period = PW'($urandom_range(0, 5));
      bs_on = 1'b1;
      model_on = 1'b1;
      for (int i = 0; i < 1500; i++) begin
        sample_valid = 1'($urandom_range(0, 1));
        rd_done = m_ready && ($urandom_range(0, 3) == 0);
        step();
      end
      model_on = 1'b0;
      rd_done = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
